// File: rtl/core_pkg.sv
// Shared definitions for the pipelined 64-bit core: datapath widths and
// the memory-stage state encoding.
package core_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned WR_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_unit.sv
// Memory-access pipeline stage: drives the data-memory request/ready handshake,
// stalls the front of the pipe during accesses, and loads the MEM/WB fields.
module mem_stage_unit
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] pc_plus_imm,
  input  logic [WR_W-1:0] wr,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            memToReg,
  input  logic            branch,
  input  logic            reg_write,
  input  logic            zero,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            stall,
  output logic            pcsrc,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] read_data_reg,
  output logic [XLEN-1:0] alu_result_reg,
  output logic [WR_W-1:0] wr_reg,
  output logic            memToReg_reg,
  output logic            reg_write_reg,
  output logic            err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0]  rdata_q;
  logic             suppress_q;

  logic mem_op;
  logic legal_op;
  logic in_access;

  assign mem_op    = mem_read | mem_write;
  assign legal_op  = (mem_read ^ mem_write) && (alu_result[2:0] == 3'b000);
  assign in_access = (state == ACCESS);

  // Request fields are decoded from the state; EX/MEM inputs are frozen by stall.
  assign mem_req       = in_access;
  assign mem_we        = in_access & mem_write;
  assign mem_addr      = in_access ? alu_result : '0;
  assign mem_wdata     = in_access ? rd2 : '0;
  assign stall         = ((state == IDLE) & mem_op) | in_access;
  assign pcsrc         = branch & zero & ~stall;
  assign branch_target = pc_plus_imm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      rdata_q        <= '0;
      suppress_q     <= 1'b0;
      err            <= 1'b0;
      read_data_reg  <= '0;
      alu_result_reg <= '0;
      wr_reg         <= '0;
      memToReg_reg   <= 1'b0;
      reg_write_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!mem_op) begin
            read_data_reg  <= '0;
            alu_result_reg <= alu_result;
            wr_reg         <= wr;
            memToReg_reg   <= memToReg;
            reg_write_reg  <= reg_write;
          end else if (legal_op) begin
            wait_cnt   <= '0;
            rdata_q    <= '0;
            suppress_q <= 1'b0;
            state      <= ACCESS;
          end else begin
            err        <= 1'b1;
            rdata_q    <= '0;
            suppress_q <= 1'b1;
            state      <= COMPLETE;
          end
        end
        ACCESS: begin
          // A ready in the final wait cycle still counts as success.
          if (mem_ready) begin
            if (mem_read) rdata_q <= mem_rdata;
            wait_cnt <= '0;
            state    <= COMPLETE;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            suppress_q <= 1'b1;
            wait_cnt   <= '0;
            state      <= COMPLETE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        COMPLETE: begin
          read_data_reg  <= rdata_q;
          alu_result_reg <= alu_result;
          wr_reg         <= wr;
          memToReg_reg   <= memToReg;
          reg_write_reg  <= reg_write & ~suppress_q;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: a cycle-timeline model of each transaction
// drives per-cycle expectations, checked every cycle plus literal spot checks.
module tb_mem_stage_unit;

  localparam int TMO = 4;
  localparam logic [63:0] NOISE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] alu_result, rd2, pc_plus_imm, mem_rdata;
  logic [31:0] wr;
  logic        mem_read, mem_write, memToReg, branch, reg_write, zero, mem_ready;
  logic        mem_req, mem_we, stall, pcsrc, memToReg_reg, reg_write_reg, err;
  logic [63:0] mem_addr, mem_wdata, branch_target, read_data_reg, alu_result_reg;
  logic [31:0] wr_reg;

  mem_stage_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .alu_result(alu_result), .rd2(rd2), .pc_plus_imm(pc_plus_imm), .wr(wr),
    .mem_read(mem_read), .mem_write(mem_write), .memToReg(memToReg),
    .branch(branch), .reg_write(reg_write), .zero(zero),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .read_data_reg(read_data_reg), .alu_result_reg(alu_result_reg), .wr_reg(wr_reg),
    .memToReg_reg(memToReg_reg), .reg_write_reg(reg_write_reg), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_stall = 0, n_req = 0, n_pc = 0;
  logic chk_en = 1'b0;

  // expected per-cycle and MEM/WB values
  logic        exp_stall, exp_req, exp_we, exp_pcsrc, exp_err, exp_m2r, exp_rw, rd_known;
  logic [63:0] exp_addr, exp_wdata, exp_bt, exp_alu, exp_rd;
  logic [31:0] exp_wr;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (stall === 1'b1) n_stall++;
    if (mem_req === 1'b1) n_req++;
    if (pcsrc === 1'b1) n_pc++;
    if (chk_en) begin
      chk("stall", 64'(stall), 64'(exp_stall));
      chk("mem_req", 64'(mem_req), 64'(exp_req));
      if (exp_req) begin
        chk("mem_we", 64'(mem_we), 64'(exp_we));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("pcsrc", 64'(pcsrc), 64'(exp_pcsrc));
      chk("branch_target", branch_target, exp_bt);
      chk("err", 64'(err), 64'(exp_err));
      chk("alu_result_reg", alu_result_reg, exp_alu);
      chk("wr_reg", 64'(wr_reg), 64'(exp_wr));
      chk("memToReg_reg", 64'(memToReg_reg), 64'(exp_m2r));
      chk("reg_write_reg", 64'(reg_write_reg), 64'(exp_rw));
      if (rd_known) chk("read_data_reg", read_data_reg, exp_rd);
    end
  end

  // One EX/MEM transaction. k = cycles after first mem_req that ready rises (-1: never).
  task automatic run_op(input logic r, input logic w, input logic [63:0] addr,
                        input logic [63:0] data, input logic [31:0] wreg,
                        input logic rwb, input logic m2r, input logic br, input logic z,
                        input logic [63:0] pci, input int k, input logic [63:0] rdata);
    logic legal;
    logic ok;
    mem_read = r; mem_write = w; alu_result = addr; rd2 = data; wr = wreg;
    reg_write = rwb; memToReg = m2r; branch = br; zero = z; pc_plus_imm = pci;
    mem_ready = 1'b0; mem_rdata = NOISE;
    exp_bt = pci; exp_req = 1'b0;
    if (!r && !w) begin
      exp_stall = 1'b0; exp_pcsrc = br & z;
      @(posedge clk); #1;
      exp_alu = addr; exp_wr = wreg; exp_rd = '0; rd_known = 1'b1;
      exp_m2r = m2r; exp_rw = rwb;
      return;
    end
    legal = (r ^ w) && (addr[2:0] == 3'b000);
    ok = 1'b0;
    exp_stall = 1'b1; exp_pcsrc = 1'b0;
    mem_ready = 1'b1;  // ready in the detect cycle must be ignored
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (legal) begin
      exp_req = 1'b1; exp_we = w; exp_addr = addr; exp_wdata = data;
      for (int c = 0; c < TMO; c++) begin
        if (c == k) begin mem_ready = 1'b1; mem_rdata = rdata; end
        @(posedge clk); #1;
        if (c == k) begin ok = 1'b1; break; end
      end
      mem_ready = 1'b0; mem_rdata = NOISE;
      if (!ok) exp_err = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
    exp_stall = 1'b0; exp_req = 1'b0; exp_pcsrc = br & z;
    mem_ready = 1'b1;  // ready in COMPLETE must be ignored
    @(posedge clk); #1;
    mem_ready = 1'b0;
    exp_alu = addr; exp_wr = wreg; exp_m2r = m2r; exp_rw = rwb & ok;
    exp_rd = (ok && r) ? rdata : 64'h0;
    rd_known = !(w && ok);
  endtask

  task automatic zero_inputs();
    mem_read = 0; mem_write = 0; alu_result = '0; rd2 = '0; wr = '0; reg_write = 0;
    memToReg = 0; branch = 0; zero = 0; pc_plus_imm = '0; mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic clear_exp();
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_pcsrc = 0; exp_err = 0; exp_m2r = 0;
    exp_rw = 0; rd_known = 1; exp_addr = '0; exp_wdata = '0; exp_bt = '0; exp_alu = '0;
    exp_rd = '0; exp_wr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 64'(mem_req), 64'h0);
    chk({tag, "_stall"}, 64'(stall), 64'h0);
    chk({tag, "_pcsrc"}, 64'(pcsrc), 64'h0);
    chk({tag, "_err"}, 64'(err), 64'h0);
    chk({tag, "_rd"}, read_data_reg, 64'h0);
    chk({tag, "_alu"}, alu_result_reg, 64'h0);
    chk({tag, "_wr"}, 64'(wr_reg), 64'h0);
    chk({tag, "_rw"}, 64'(reg_write_reg), 64'h0);
    chk({tag, "_m2r"}, 64'(memToReg_reg), 64'h0);
    chk({tag, "_addr"}, mem_addr, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, q0, p0;
    reset = 1'b1;
    zero_inputs();
    clear_exp();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("reset");
    chk_en = 1'b1;

    // ALU op passes straight through in one cycle with no stall
    s0 = n_stall;
    run_op(0, 0, 64'h40, 64'h0, 32'd5, 1, 0, 0, 0, 64'h0, -1, 64'h0);
    chk("alu_alu_result_reg", alu_result_reg, 64'h40);
    chk("alu_wr_reg", 64'(wr_reg), 64'd5);
    chk("alu_reg_write_reg", 64'(reg_write_reg), 64'd1);
    chk("alu_stall_cycles", 64'(n_stall - s0), 64'd0);

    // load, ready two cycles after the request rises
    s0 = n_stall; q0 = n_req;
    run_op(1, 0, 64'h100, 64'h0, 32'd7, 1, 1, 0, 0, 64'h0, 2, 64'hDEADBEEF);
    chk("load_stall_cycles", 64'(n_stall - s0), 64'd4);
    chk("load_req_cycles", 64'(n_req - q0), 64'd3);
    chk("load_read_data_reg", read_data_reg, 64'hDEADBEEF);
    chk("load_memToReg_reg", 64'(memToReg_reg), 64'd1);

    // store with same-cycle ready
    s0 = n_stall; q0 = n_req;
    run_op(0, 1, 64'h8, 64'h1234, 32'd0, 0, 0, 0, 0, 64'h0, 0, 64'h0);
    chk("store_stall_cycles", 64'(n_stall - s0), 64'd2);
    chk("store_req_cycles", 64'(n_req - q0), 64'd1);
    chk("store_err", 64'(err), 64'd0);

    // ready in the last allowed cycle is a success
    s0 = n_stall;
    run_op(1, 0, 64'h10, 64'h0, 32'd9, 1, 1, 0, 0, 64'h0, TMO - 1, 64'hCAFE_F00D_0000_0001);
    chk("lastcyc_stall_cycles", 64'(n_stall - s0), 64'd5);
    chk("lastcyc_err", 64'(err), 64'd0);
    chk("lastcyc_rd", read_data_reg, 64'hCAFE_F00D_0000_0001);

    // branch without a memory op
    p0 = n_pc;
    run_op(0, 0, 64'h0, 64'h0, 32'd0, 0, 0, 1, 1, 64'h1000, -1, 64'h0);
    chk("branch_pcsrc_cycles", 64'(n_pc - p0), 64'd1);

    // misaligned load: no request, error, bubble
    q0 = n_req;
    run_op(1, 0, 64'h103, 64'h0, 32'd3, 1, 1, 0, 0, 64'h0, 0, 64'h55);
    chk("misalign_req_cycles", 64'(n_req - q0), 64'd0);
    chk("misalign_err", 64'(err), 64'd1);
    chk("misalign_reg_write_reg", 64'(reg_write_reg), 64'd0);

    // timeout: request held exactly TIMEOUT cycles, then bubble
    s0 = n_stall; q0 = n_req;
    run_op(1, 0, 64'h20, 64'h0, 32'd4, 1, 1, 0, 0, 64'h0, -1, 64'h0);
    chk("timeout_req_cycles", 64'(n_req - q0), 64'd4);
    chk("timeout_stall_cycles", 64'(n_stall - s0), 64'd5);
    chk("timeout_reg_write_reg", 64'(reg_write_reg), 64'd0);

    // later legal access still completes; err is sticky
    run_op(1, 0, 64'h28, 64'h0, 32'd11, 1, 1, 0, 0, 64'h0, 1, 64'h0123_4567_89AB_CDEF);
    chk("after_to_rd", read_data_reg, 64'h0123_4567_89AB_CDEF);
    chk("after_to_rw", 64'(reg_write_reg), 64'd1);
    chk("after_to_err", 64'(err), 64'd1);

    // branch paired with a store resolves only after the stall
    p0 = n_pc;
    run_op(0, 1, 64'h30, 64'hABCD, 32'd0, 0, 0, 1, 1, 64'h2000, 1, 64'h0);
    chk("brmem_pcsrc_cycles", 64'(n_pc - p0), 64'd1);

    // reset in the middle of an access
    mem_read = 1; mem_write = 0; alu_result = 64'h200; wr = 32'd6; reg_write = 1;
    memToReg = 1; branch = 0; zero = 0; pc_plus_imm = '0; mem_ready = 0;
    exp_stall = 1; exp_req = 0; exp_pcsrc = 0; exp_bt = '0;
    @(posedge clk); #1;
    exp_req = 1; exp_we = 0; exp_addr = 64'h200; exp_wdata = rd2;
    @(posedge clk); #1;
    chk("pre_reset_req", 64'(mem_req), 64'd1);
    chk_en = 1'b0;
    reset = 1'b1;
    zero_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    chk_all_zero("midreset");
    clear_exp();
    chk_en = 1'b1;

    // counter and state start clean after reset
    s0 = n_stall;
    run_op(1, 0, 64'h48, 64'h0, 32'd12, 1, 1, 0, 0, 64'h0, 0, 64'h77);
    chk("postreset_stall_cycles", 64'(n_stall - s0), 64'd2);
    chk("postreset_rd", read_data_reg, 64'h77);

    // both read and write set is illegal
    q0 = n_req;
    run_op(1, 1, 64'h50, 64'h0, 32'd13, 1, 0, 0, 0, 64'h0, 0, 64'h0);
    chk("both_req_cycles", 64'(n_req - q0), 64'd0);
    chk("both_err", 64'(err), 64'd1);

    run_op(0, 0, 64'h60, 64'h0, 32'd14, 1, 0, 0, 0, 64'h0, -1, 64'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
